// File: rtl/s_axi_write.sv
// rtl/s_axi_write.sv - AXI4-Lite write-side slave for the DFX sequencer register file
//
// Purpose:
//   Accepts one AXI4-Lite write at a time. AW and W may arrive together or
//   in either order. Once both beats are held, the registered address is
//   decoded. The write then commits as one of:
//     - a one-cycle strobe into bank0 (sequencer control/config), or
//     - a req/ready transfer into a bank1 slot (per-slot DMA descriptor), or
//     - nothing, when the access is an error.
//   A B response is returned once the commit finishes.
//
// Address map (on the registered address a):
//   a[15:14] = 00 : bank0, register select a[13:6]
//   a[15:14] = 01 : bank1, slot index a[7:6], field select a[5:2]
//                   field 0101 is read-only; fields above 0101 are unmapped
//   a[15:14] = 1x : unmapped
//   A partial byte strobe is always an error. AWADDR[1:0] are ignored.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   S_AXI_AW*             write address channel (AWREADY is combinational)
//   S_AXI_W*              write data channel (WREADY is combinational)
//   S_AXI_B*              write response channel (BRESP 00 OKAY, 10 SLVERR)
//   ext_bank0_in_*        bank0 write strobe, select and data
//   ext_bank1_in_*        bank1 request, slot index, field select, data, ready

module s_axi_write #(
  parameter int ADDR_WIDTH        = 16,
  parameter int DATA_WIDTH        = 32,
  parameter int BANK1_INDEX_WIDTH = 2,
  parameter int BANK0_SEL_WIDTH   = 8,
  parameter int BANK1_SEL_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,

  input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,

  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,

  output logic                         ext_bank0_in_wr,
  output logic [BANK0_SEL_WIDTH-1:0]   ext_bank0_in_sel,
  output logic [DATA_WIDTH-1:0]        ext_bank0_in_data,

  output logic                         ext_bank1_in_req,
  output logic [BANK1_INDEX_WIDTH-1:0] ext_bank1_in_index,
  output logic [BANK1_SEL_WIDTH-1:0]   ext_bank1_in_sel,
  output logic [DATA_WIDTH-1:0]        ext_bank1_in_data,
  input  logic                         ext_bank1_in_ready
);

  localparam logic [1:0] REGION_BANK0 = 2'b00;
  localparam logic [1:0] REGION_BANK1 = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  // Bank1 field 0101 is the read-only profile field; everything above it
  // is unmapped, so a single ">=" covers both rejections.
  localparam logic [BANK1_SEL_WIDTH-1:0] B1_FIRST_BAD_FIELD = BANK1_SEL_WIDTH'(5);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_W  = 3'd1,
    ST_WAIT_AW = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;

  // Address bits [1:0] never participate in decode, so they are not stored.
  logic [ADDR_WIDTH-1:2]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_wstrb;
  logic [1:0]                r_bresp;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic [1:0]                w_region;
  logic [BANK1_SEL_WIDTH-1:0] w_b1_field;
  logic                      w_strb_full;
  logic                      w_err;
  logic                      w_is_bank0;
  logic                      w_is_bank1;
  logic                      w_in_commit;
  logic                      w_commit_done;
  logic                      w_unused;

  assign w_unused = &{1'b0, S_AXI_AWADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Channel acceptance. Only one write may be outstanding, so both ready
  // signals are low in COMMIT and RESP. Ready is also held low while reset is
  // asserted so a master never sees a handshake that the slave then discards.
  // ---------------------------------------------------------------------------
  assign S_AXI_AWREADY = S_AXI_AWVALID && !reset &&
                         (r_state == ST_IDLE || r_state == ST_WAIT_AW);
  assign S_AXI_WREADY  = S_AXI_WVALID && !reset &&
                         (r_state == ST_IDLE || r_state == ST_WAIT_W);

  assign w_aw_hs = S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WREADY;

  // ---------------------------------------------------------------------------
  // Decode of the registered beats. Only consulted in COMMIT.
  // ---------------------------------------------------------------------------
  assign w_region    = r_addr[ADDR_WIDTH-1 -: 2];
  assign w_b1_field  = r_addr[2 +: BANK1_SEL_WIDTH];
  assign w_strb_full = &r_wstrb;

  assign w_err = w_region[1] ||
                 !w_strb_full ||
                 (w_region == REGION_BANK1 && w_b1_field >= B1_FIRST_BAD_FIELD);

  assign w_is_bank0 = !w_err && (w_region == REGION_BANK0);
  assign w_is_bank1 = !w_err && (w_region == REGION_BANK1);

  assign w_in_commit = (r_state == ST_COMMIT);

  // Bank0 and error commits finish in their single COMMIT cycle; a bank1
  // commit waits for the slot to accept the request.
  assign w_commit_done = w_in_commit && (!w_is_bank1 || ext_bank1_in_ready);

  // ---------------------------------------------------------------------------
  // State register and captured beats
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_bresp <= RESP_OKAY;
    end else begin
      r_state <= w_next_state;
      if (w_aw_hs) begin
        r_addr <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      // BRESP is latched on the way out of COMMIT and then held for all of RESP.
      if (w_commit_done) begin
        r_bresp <= w_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_next_state = ST_COMMIT;
        end else if (w_aw_hs) begin
          w_next_state = ST_WAIT_W;
        end else if (w_w_hs) begin
          w_next_state = ST_WAIT_AW;
        end
      end
      ST_WAIT_W: begin
        if (w_w_hs) begin
          w_next_state = ST_COMMIT;
        end
      end
      ST_WAIT_AW: begin
        if (w_aw_hs) begin
          w_next_state = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (w_commit_done) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        // RESP always lasts at least one cycle, even with BREADY pre-asserted.
        if (S_AXI_BREADY) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Strobe/request are decoded from COMMIT, so the bank0 strobe is
  // exactly one cycle wide and the bank1 request falls in the cycle after the
  // accepting req && ready cycle (or after reset is sampled).
  // ---------------------------------------------------------------------------
  assign S_AXI_BVALID = (r_state == ST_RESP);
  assign S_AXI_BRESP  = r_bresp;

  assign ext_bank0_in_wr   = w_in_commit && w_is_bank0;
  assign ext_bank0_in_sel  = r_addr[6 +: BANK0_SEL_WIDTH];
  assign ext_bank0_in_data = r_wdata;

  assign ext_bank1_in_req   = w_in_commit && w_is_bank1;
  assign ext_bank1_in_index = r_addr[6 +: BANK1_INDEX_WIDTH];
  assign ext_bank1_in_sel   = w_b1_field;
  assign ext_bank1_in_data  = r_wdata;

endmodule

// File: tb/tb_s_axi_write.sv
// tb/tb_s_axi_write.sv - self-checking bench for s_axi_write

module tb_s_axi_write;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic        ext_bank0_in_wr;
  logic [7:0]  ext_bank0_in_sel;
  logic [31:0] ext_bank0_in_data;
  logic        ext_bank1_in_req;
  logic [1:0]  ext_bank1_in_index;
  logic [3:0]  ext_bank1_in_sel;
  logic [31:0] ext_bank1_in_data;
  logic        ext_bank1_in_ready;

  always #5 clk = ~clk;

  s_axi_write dut (
    .clk                (clk),
    .reset              (reset),
    .S_AXI_AWADDR       (S_AXI_AWADDR),
    .S_AXI_AWVALID      (S_AXI_AWVALID),
    .S_AXI_AWREADY      (S_AXI_AWREADY),
    .S_AXI_WDATA        (S_AXI_WDATA),
    .S_AXI_WSTRB        (S_AXI_WSTRB),
    .S_AXI_WVALID       (S_AXI_WVALID),
    .S_AXI_WREADY       (S_AXI_WREADY),
    .S_AXI_BRESP        (S_AXI_BRESP),
    .S_AXI_BVALID       (S_AXI_BVALID),
    .S_AXI_BREADY       (S_AXI_BREADY),
    .ext_bank0_in_wr    (ext_bank0_in_wr),
    .ext_bank0_in_sel   (ext_bank0_in_sel),
    .ext_bank0_in_data  (ext_bank0_in_data),
    .ext_bank1_in_req   (ext_bank1_in_req),
    .ext_bank1_in_index (ext_bank1_in_index),
    .ext_bank1_in_sel   (ext_bank1_in_sel),
    .ext_bank1_in_data  (ext_bank1_in_data),
    .ext_bank1_in_ready (ext_bank1_in_ready)
  );

  // kind: 0 bank0 write, 1 bank1 write, 2 error
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          rdy_lat;
    int          brdy_lat;
    int          kind;
    logic [31:0] sel;
    logic [31:0] idx;
    logic [31:0] bresp;
  } vec_t;

  int    n_vec = 0;
  int    n_err = 0;
  string g_tag = "";

  // Observations of the last transaction
  int          o_wr_cnt, o_wr_cyc, o_req_cnt, o_bv_first, o_bv_cnt;
  bit          o_req_unstable, o_bresp_unstable, o_timeout;
  logic [31:0] o_wr_sel, o_wr_data, o_req_idx, o_req_sel, o_req_data, o_bresp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", g_tag, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    S_AXI_AWVALID      = 1'b0;
    S_AXI_WVALID       = 1'b0;
    S_AXI_BREADY       = 1'b0;
    ext_bank1_in_ready = 1'b0;
  endtask

  // Reference: decode rules expressed as plain arithmetic on the address.
  task automatic model(input logic [15:0] a, input logic [3:0] s, output int kind,
                       output logic [31:0] sel, output logic [31:0] idx,
                       output logic [31:0] bresp);
    int region, field;
    bit err;
    region = int'(a) / 16384;
    field  = (int'(a) / 4) % 16;
    err    = (region >= 2) || (s != 4'hF) || (region == 1 && field >= 5);
    kind   = err ? 2 : region;
    sel    = (kind == 0) ? 32'((int'(a) / 64) % 256) : 32'(field);
    idx    = 32'((int'(a) / 64) % 4);
    bresp  = err ? 32'd2 : 32'd0;
  endtask

  // Drives one write with the given per-channel delays and sink latencies,
  // recording what the DUT does on every cycle. Entered and left just after
  // a rising edge.
  task automatic run_txn(input logic [15:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_dly, input int w_dly,
                         input int rdy_lat, input int brdy_lat);
    bit aw_done = 0;
    bit w_done  = 0;
    bit fin     = 0;
    int c       = 0;
    o_wr_cnt = 0; o_wr_cyc = -1; o_req_cnt = 0; o_bv_first = -1; o_bv_cnt = 0;
    o_req_unstable = 0; o_bresp_unstable = 0; o_timeout = 0;
    o_wr_sel = 0; o_wr_data = 0; o_req_idx = 0; o_req_sel = 0; o_req_data = 0; o_bresp = 0;
    while (!fin && c < 200) begin
      S_AXI_AWADDR       = addr;
      S_AXI_AWVALID      = !aw_done && (c >= aw_dly);
      S_AXI_WDATA        = data;
      S_AXI_WSTRB        = strb;
      S_AXI_WVALID       = !w_done && (c >= w_dly);
      ext_bank1_in_ready = (o_req_cnt >= rdy_lat);
      S_AXI_BREADY       = (o_bv_cnt >= brdy_lat);
      @(negedge clk);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      if (ext_bank0_in_wr) begin
        if (o_wr_cnt == 0) begin
          o_wr_cyc  = c;
          o_wr_sel  = 32'(ext_bank0_in_sel);
          o_wr_data = ext_bank0_in_data;
        end
        o_wr_cnt++;
      end
      if (ext_bank1_in_req) begin
        if (o_req_cnt == 0) begin
          o_req_idx  = 32'(ext_bank1_in_index);
          o_req_sel  = 32'(ext_bank1_in_sel);
          o_req_data = ext_bank1_in_data;
        end else if (o_req_idx != 32'(ext_bank1_in_index) || o_req_sel != 32'(ext_bank1_in_sel)
                     || o_req_data != ext_bank1_in_data) begin
          o_req_unstable = 1;
        end
        o_req_cnt++;
      end
      if (S_AXI_BVALID) begin
        if (o_bv_cnt == 0) begin
          o_bv_first = c;
          o_bresp    = 32'(S_AXI_BRESP);
        end else if (o_bresp != 32'(S_AXI_BRESP)) begin
          o_bresp_unstable = 1;
        end
        o_bv_cnt++;
        if (S_AXI_BREADY) fin = 1;
      end
      tick();
      c++;
    end
    o_timeout = !fin;
    idle_inputs();
  endtask

  // Latency expectations: both beats held by cycle t = max(aw_dly, w_dly);
  // COMMIT at t+1; RESP at t+2, plus one cycle per ready-low bank1 cycle.
  task automatic check_txn(input int kind, input logic [31:0] data, input logic [31:0] sel,
                           input logic [31:0] idx, input logic [31:0] bresp,
                           input int aw_dly, input int w_dly, input int rdy_lat,
                           input int brdy_lat);
    int t;
    t = (aw_dly > w_dly) ? aw_dly : w_dly;
    chk("timeout", 32'(o_timeout), 0);
    chk("wr_cnt", o_wr_cnt, (kind == 0) ? 1 : 0);
    if (kind == 0) begin
      chk("wr_cyc", o_wr_cyc, t + 1);
      chk("wr_sel", o_wr_sel, sel);
      chk("wr_data", o_wr_data, data);
    end
    chk("req_cnt", o_req_cnt, (kind == 1) ? rdy_lat + 1 : 0);
    if (kind == 1) begin
      chk("req_idx", o_req_idx, idx);
      chk("req_sel", o_req_sel, sel);
      chk("req_data", o_req_data, data);
      chk("req_stable", 32'(o_req_unstable), 0);
    end
    chk("bresp", o_bresp, bresp);
    chk("bv_first", o_bv_first, t + 2 + ((kind == 1) ? rdy_lat : 0));
    chk("bv_cnt", o_bv_cnt, brdy_lat + 1);
    chk("bresp_stable", 32'(o_bresp_unstable), 0);
  endtask

  vec_t tbl [12];

  initial begin
    int          stall, nw, nb, k, kind;
    int          hs [2];
    logic [31:0] sels [4];
    logic [31:0] m_sel, m_idx, m_bresp;
    logic [15:0] a;
    logic [3:0]  s;
    bit          hs_flag;
    int          aw_d, w_d, r_l, b_l;

    tbl[0]  = '{16'h0100, 32'h00000001, 4'hF, 0, 0, 0, 0, 0, 32'h04, 32'h0, 32'h0};
    tbl[1]  = '{16'h4088, 32'hDEADBEEF, 4'hF, 3, 0, 0, 0, 1, 32'h2, 32'h2, 32'h0};
    tbl[2]  = '{16'h4044, 32'h12345678, 4'hF, 0, 0, 5, 3, 1, 32'h1, 32'h1, 32'h0};
    tbl[3]  = '{16'h8000, 32'h11111111, 4'hF, 0, 0, 0, 0, 2, 32'h0, 32'h0, 32'h2};
    tbl[4]  = '{16'h4014, 32'h22222222, 4'hF, 0, 0, 0, 0, 2, 32'h0, 32'h0, 32'h2};
    tbl[5]  = '{16'h0100, 32'h33333333, 4'h3, 0, 0, 0, 0, 2, 32'h0, 32'h0, 32'h2};
    tbl[6]  = '{16'hC004, 32'h44444444, 4'hF, 1, 0, 0, 1, 2, 32'h0, 32'h0, 32'h2};
    tbl[7]  = '{16'h4018, 32'h55555555, 4'hF, 0, 1, 0, 0, 2, 32'h0, 32'h0, 32'h2};
    tbl[8]  = '{16'h4010, 32'h66666666, 4'hF, 0, 2, 1, 0, 1, 32'h4, 32'h0, 32'h0};
    tbl[9]  = '{16'h3FC3, 32'h77777777, 4'hF, 1, 1, 0, 0, 0, 32'hFF, 32'h0, 32'h0};
    tbl[10] = '{16'h40FC, 32'h88888888, 4'hF, 0, 0, 0, 0, 2, 32'h0, 32'h0, 32'h2};
    tbl[11] = '{16'h0040, 32'hA5A5A5A5, 4'hF, 2, 0, 0, 2, 0, 32'h1, 32'h0, 32'h0};

    // Reset state, with valids asserted to show reset blocks acceptance
    S_AXI_AWADDR = 16'h0100; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF;
    idle_inputs();
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    g_tag = "reset";
    chk("awready", 32'(S_AXI_AWREADY), 0);
    chk("wready", 32'(S_AXI_WREADY), 0);
    chk("bvalid", 32'(S_AXI_BVALID), 0);
    chk("bresp", 32'(S_AXI_BRESP), 0);
    chk("wr", 32'(ext_bank0_in_wr), 0);
    chk("req", 32'(ext_bank1_in_req), 0);
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 12; i++) begin
      g_tag = $sformatf("tbl%0d", i);
      run_txn(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly,
              tbl[i].rdy_lat, tbl[i].brdy_lat);
      check_txn(tbl[i].kind, tbl[i].data, tbl[i].sel, tbl[i].idx, tbl[i].bresp,
                tbl[i].aw_dly, tbl[i].w_dly, tbl[i].rdy_lat, tbl[i].brdy_lat);
      tick();
    end

    // Randomized writes against the reference decode
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      k = int'($urandom_range(0, 7));
      a[15:14] = (k < 3) ? 2'b00 : (k < 6) ? 2'b01 : (k == 6) ? 2'b10 : 2'b11;
      if (a[15:14] == 2'b01) a[5:2] = 4'($urandom_range(0, 7));
      s = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      aw_d = int'($urandom_range(0, 3));
      w_d  = int'($urandom_range(0, 3));
      r_l  = int'($urandom_range(0, 3));
      b_l  = int'($urandom_range(0, 2));
      model(a, s, kind, m_sel, m_idx, m_bresp);
      g_tag = $sformatf("rnd%0d_a%04h_s%0h", i, a, s);
      run_txn(a, $urandom, s, aw_d, w_d, r_l, b_l);
      check_txn(kind, o_wr_cnt > 0 ? o_wr_data : o_req_data, m_sel, m_idx, m_bresp,
                aw_d, w_d, r_l, b_l);
      tick();
    end

    // Reset after AW only: captured address is discarded, W alone parks in WAIT_AW
    g_tag = "rst_mid";
    S_AXI_AWADDR = 16'h0100; S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    chk("aw_accept", 32'(S_AXI_AWREADY), 1);
    tick();
    S_AXI_AWVALID = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("bvalid", 32'(S_AXI_BVALID), 0);
    chk("bresp", 32'(S_AXI_BRESP), 0);
    chk("wr", 32'(ext_bank0_in_wr), 0);
    tick();
    S_AXI_WDATA = 32'h00000055; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge clk);
    chk("w_accept", 32'(S_AXI_WREADY), 1);
    tick();
    S_AXI_WVALID = 1'b0;
    nw = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ext_bank0_in_wr || ext_bank1_in_req || S_AXI_BVALID) nw++;
      tick();
    end
    chk("no_activity", nw, 0);
    S_AXI_WDATA = 32'h00000099; S_AXI_WVALID = 1'b1;
    @(negedge clk);
    chk("wait_aw_wready", 32'(S_AXI_WREADY), 0);
    tick();
    S_AXI_WVALID = 1'b0;
    S_AXI_AWADDR = 16'h0200; S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    chk("aw_accept2", 32'(S_AXI_AWREADY), 1);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(negedge clk);
    chk("wr_after", 32'(ext_bank0_in_wr), 1);
    chk("wr_sel_after", 32'(ext_bank0_in_sel), 32'h08);
    chk("wr_data_after", ext_bank0_in_data, 32'h00000055);
    tick();
    @(negedge clk);
    chk("bvalid_after", 32'(S_AXI_BVALID), 1);
    tick();
    idle_inputs();
    tick();

    // Reset while a bank1 request is stalled: req drops, no response follows
    g_tag = "rst_b1";
    S_AXI_AWADDR = 16'h4044; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; ext_bank1_in_ready = 1'b0;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge clk);
    chk("req_up", 32'(ext_bank1_in_req), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; S_AXI_BREADY = 1'b1;
    nb = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ext_bank1_in_req || S_AXI_BVALID) nb++;
      tick();
    end
    chk("req_bv_gone", nb, 0);
    idle_inputs();

    // Back-to-back writes with valids held and BREADY tied high
    g_tag = "b2b";
    k = 0; stall = 0; nw = 0; nb = 0; hs[0] = -1; hs[1] = -1;
    S_AXI_BREADY = 1'b1; S_AXI_WSTRB = 4'hF;
    for (int c = 0; c < 12; c++) begin
      S_AXI_AWVALID = (k < 2);
      S_AXI_WVALID  = (k < 2);
      S_AXI_AWADDR  = (k == 0) ? 16'h0080 : 16'h00C0;
      S_AXI_WDATA   = 32'(k + 1);
      hs_flag = 0;
      @(negedge clk);
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        hs[k] = c;
        hs_flag = 1;
      end
      if (S_AXI_AWVALID && !S_AXI_AWREADY) stall++;
      if (ext_bank0_in_wr && nw < 4) begin
        sels[nw] = 32'(ext_bank0_in_sel);
        nw++;
      end
      if (S_AXI_BVALID) nb++;
      tick();
      if (hs_flag) k++;
    end
    idle_inputs();
    chk("hs0", hs[0], 0);
    chk("hs1", hs[1], 3);
    chk("aw_stall", stall, 2);
    chk("strobes", nw, 2);
    chk("responses", nb, 2);
    if (nw == 2) begin
      chk("sel0", sels[0], 32'h02);
      chk("sel1", sels[1], 32'h03);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/s_axi_write.md
Name: s_axi_write

Overview:
- AXI4-Lite write-side slave of the DFX sequencer register file; companion to the read-side slave and decodes the same address map.
- Accepts AW and W independently, in either order, then decodes the address.
- Commits the data either as a single-cycle write strobe into bank0 (sequencer control/config), or as a req/ready write into a bank1 slot (per-slot DMA descriptor).
- Returns a B response after the commit completes.

Parameters:
ADDR_WIDTH, 16, AXI address width
DATA_WIDTH, 32, AXI data width
BANK1_INDEX_WIDTH, 2, slot index width (4 slots)
BANK0_SEL_WIDTH, 8, bank0 register select width (addr[13:6])
BANK1_SEL_WIDTH, 4, bank1 field select width (addr[5:2])

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  address valid
S_AXI_AWREADY  out  1  address accepted
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes
S_AXI_WVALID  in  1  data valid
S_AXI_WREADY  out  1  data accepted
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  response valid
S_AXI_BREADY  in  1  response accepted
ext_bank0_in_wr  out  1  one-cycle bank0 write strobe
ext_bank0_in_sel  out  BANK0_SEL_WIDTH  bank0 register select
ext_bank0_in_data  out  DATA_WIDTH  bank0 write data
ext_bank1_in_req  out  1  bank1 write request
ext_bank1_in_index  out  BANK1_INDEX_WIDTH  slot index (addr[7:6])
ext_bank1_in_sel  out  BANK1_SEL_WIDTH  field select
ext_bank1_in_data  out  DATA_WIDTH  bank1 write data
ext_bank1_in_ready  in  1  bank1 accepts request this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- On reset: state IDLE; AWREADY=0, WREADY=0, BVALID=0, BRESP=00, ext_bank0_in_wr=0, ext_bank1_in_req=0; address/data/strobe registers cleared.
- States: IDLE, WAIT_W (address held), WAIT_AW (data held), COMMIT, RESP.
- S_AXI_AWREADY = AWVALID && (state==IDLE || state==WAIT_AW).
- S_AXI_WREADY = WVALID && (state==IDLE || state==WAIT_W).
- A beat accepted on its handshake is registered.
- IDLE transitions:
  - AW and W both valid: capture both, go to COMMIT.
  - AW only: go to WAIT_W.
  - W only: go to WAIT_AW.
- WAIT_W goes to COMMIT on W. WAIT_AW goes to COMMIT on AW.
- Decode in COMMIT, on registered addr a:
  - err = (a[15:14] ∈ {10,11}) or (WSTRB != all-ones) or (a[15:14]==01 and a[5:2]==0101, the read-only profile field) or (a[15:14]==01 and a[5:2] > 0101).
  - err: no side effect; go to RESP with BRESP=10.
  - a[15:14]==00: ext_bank0_in_wr=1 for exactly one cycle; sel=a[13:6], data=WDATA. Go to RESP with BRESP=00. Bank0 owns ignore-on-unmapped-select.
  - a[15:14]==01: ext_bank1_in_req=1 with index/sel/data stable, held while ready=0. The transfer happens in the cycle req && ready. That cycle: req drops next cycle; go to RESP with BRESP=00. No timeout.
- RESP: BVALID=1 and BRESP held stable until BREADY; then IDLE. AWREADY/WREADY are 0 in COMMIT and RESP (one outstanding write).
- Latency: AW+W in cycle N → bank0 strobe in N+1 → BVALID in N+2. Bank1 adds one cycle per ready-low cycle.
- ext_bank*_in_* data/sel/index are driven from the registered values in all states; they are meaningful only when wr/req is high.
- Reset asserted mid-transaction (any state) discards the captured beat and any pending B response. A bank1 req drops in the cycle after reset samples high.
- BREADY pre-asserted: RESP still lasts at least one cycle.
- AWADDR[1:0] are ignored.

Test Plan:
- Bank0 write: AW=0x0100 and W=0x00000001/WSTRB=F in the same cycle → ext_bank0_in_wr pulse 1 cycle at N+1 with sel=0x04, data=1; BVALID at N+2, BRESP=00.
- Order independence: W=0xDEADBEEF first, AW=0x4088 three cycles later → bank1 req with index=2, sel=2, data=0xDEADBEEF; ready tied 1 → BVALID two cycles after AW.
- Bank1 backpressure: AW=0x4044, ready held 0 for 5 cycles → req stays 1 with stable index=1, sel=1; one cycle after ready rises req=0 and BVALID=1; BVALID held until BREADY is given 3 cycles later.
- Errors, each with no wr/req pulse and BRESP=10: AW=0x8000; AW=0x4014 (profile field); WSTRB=0x3 to 0x0100.
- Reset mid-op: AW accepted, then reset asserted before W → all outputs return to reset values; a following W alone leads to WAIT_AW with no strobe.
- Back-to-back: two full writes with BREADY=1 → AWREADY low during COMMIT/RESP; second write is accepted only after returning to IDLE; two strobes, two responses.
